// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : KGP-RISC program-counter stage feeding instruction fetch.
//            Handles sequential advance, redirect, stall and sticky halt.
//            Optional macro PC_MISALIGN_TRAP_EN enables the FAULT state.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int                  PC_WIDTH  = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  STEP      = 4,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 halt,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_plus4,
  output logic                 fetch_valid,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_BUBBLE = 3'd2;
  localparam logic [2:0] S_HALT   = 3'd3;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [2:0] S_FAULT  = 3'd4;
`endif

  localparam logic [PC_WIDTH-1:0]  c_STEP       = PC_WIDTH'(STEP);
  localparam logic [PC_WIDTH-1:0]  c_ALIGN_MASK = ~(PC_WIDTH'(3));
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

  logic [2:0]           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [PC_WIDTH-1:0]  w_pc_seq;
`ifdef PC_MISALIGN_TRAP_EN
  logic                 fault_q, fault_d;
  logic                 w_misaligned;

  assign w_misaligned = |branch_target[1:0];
`endif

  assign w_pc_seq  = pc_q + c_STEP;
  assign w_cnt_inc = (&cnt_q) ? cnt_q : (cnt_q + c_CNT_ONE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    fault_d  = fault_q;
`endif
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        valid_d = 1'b1;
      end
      S_RUN, S_BUBBLE: begin
        if (halt) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          valid_d  = 1'b0;
        end else if (branch_valid) begin
          // Redirects win over stall so a taken branch is never lost.
          cnt_d   = w_cnt_inc;
          valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
          if (w_misaligned) begin
            state_d = S_FAULT;
            pc_d    = branch_target;
            fault_d = 1'b1;
          end else begin
            state_d = S_BUBBLE;
            pc_d    = branch_target & c_ALIGN_MASK;
          end
`else
          state_d = S_BUBBLE;
          pc_d    = branch_target & c_ALIGN_MASK;
`endif
        end else if (stall) begin
          state_d = state_q;
        end else if (state_q == S_BUBBLE) begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end else begin
          pc_d = w_pc_seq;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
`ifdef PC_MISALIGN_TRAP_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d  = S_BOOT;
        pc_d     = RESET_PC;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
`ifdef PC_MISALIGN_TRAP_EN
      fault_q  <= fault_d;
`endif
    end
  end

  assign pc             = pc_q;
  assign pc_plus4       = w_pc_seq;
  assign fetch_valid    = valid_q;
  assign halted         = halted_q;
  assign redirect_count = cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign fault          = fault_q;
`else
  assign fault          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Randomized self-checking bench for pc_sequencer against a
//            flag-based behavioural model; honours PC_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit c_TRAP = 1'b1;
`else
  localparam bit c_TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [11:0] branch_target = '0;
  logic        halt = 1'b0;

  logic [11:0] pc, pc_plus4, pc_s, pc_plus4_s;
  logic        fetch_valid, halted, fault, fetch_valid_s, halted_s, fault_s;
  logic [15:0] redirect_count;
  logic [3:0]  redirect_count_s;

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc, m_cnt;
  bit m_valid, m_halted, m_fault, m_booted, m_bubble;

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .halt(halt), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .halted(halted), .fault(fault),
    .redirect_count(redirect_count)
  );

  pc_sequencer #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .halt(halt), .pc(pc_s), .pc_plus4(pc_plus4_s),
    .fetch_valid(fetch_valid_s), .halted(halted_s), .fault(fault_s),
    .redirect_count(redirect_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    if (!rst) begin
      m_pc = 0; m_cnt = 0; m_valid = 0; m_halted = 0;
      m_fault = 0; m_booted = 0; m_bubble = 0;
    end else if (!m_booted) begin
      m_booted = 1; m_valid = 1;
    end else if (m_halted || m_fault) begin
      // sticky: nothing changes
    end else if (halt) begin
      m_halted = 1; m_valid = 0;
    end else if (branch_valid) begin
      m_cnt++;
      m_valid = 0;
      if (c_TRAP && (int'(branch_target) % 4 != 0)) begin
        m_pc = int'(branch_target);
        m_fault = 1;
      end else begin
        m_pc = (int'(branch_target) / 4) * 4;
        m_bubble = 1;
      end
    end else if (stall) begin
      // hold
    end else if (m_bubble) begin
      m_bubble = 0; m_valid = 1;
    end else begin
      m_pc = (m_pc + 4) % 4096;
    end
  endfunction

  task automatic compare_all();
    chk("pc",           pc,                m_pc);
    chk("pc_plus4",     pc_plus4,          (m_pc + 4) % 4096);
    chk("fetch_valid",  fetch_valid,       m_valid);
    chk("halted",       halted,            m_halted);
    chk("fault",        fault,             m_fault);
    chk("count16",      redirect_count,    (m_cnt > 65535) ? 65535 : m_cnt);
    chk("count4",       redirect_count_s,  (m_cnt > 15) ? 15 : m_cnt);
    chk("pc_sat_inst",  pc_s,              m_pc);
  endtask

  task automatic step(input bit r, input bit s, input bit b, input logic [11:0] t, input bit h);
    rst = r; stall = s; branch_valid = b; branch_target = t; halt = h;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_step();
    // reset and boot
    step(0, 0, 0, 12'h0, 0);
    step(0, 1, 1, 12'h123, 1);
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", fetch_valid, 32'h0);
    step(1, 0, 0, 12'h0, 0);
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", fetch_valid, 32'h1);
    step(1, 0, 0, 12'h0, 0);
    step(1, 0, 0, 12'h0, 0);
    step(1, 0, 0, 12'h0, 0);
    chk("seq_pc_0c", pc, 32'hC);

    // wrap at the top of the address space
    step(1, 0, 1, 12'hFF8, 0);
    chk("redir_ff8", pc, 32'hFF8);
    chk("redir_valid0", fetch_valid, 32'h0);
    step(1, 0, 0, 12'h0, 0);
    chk("bubble_done", fetch_valid, 32'h1);
    step(1, 0, 0, 12'h0, 0);
    chk("pc_ffc", pc, 32'hFFC);
    chk("plus4_wrap", pc_plus4, 32'h0);
    step(1, 0, 0, 12'h0, 0);
    chk("pc_wrap0", pc, 32'h0);

    // branch with stall, then stalled bubble
    step(0, 0, 0, 12'h0, 0);
    step(1, 0, 0, 12'h0, 0);
    step(1, 1, 1, 12'h040, 0);
    chk("stall_br_pc", pc, 32'h40);
    chk("stall_br_cnt", redirect_count, 32'h1);
    step(1, 1, 0, 12'h0, 0);
    chk("stall_bubble_valid", fetch_valid, 32'h0);
    step(1, 0, 0, 12'h0, 0);
    chk("bubble_release", fetch_valid, 32'h1);

    // halt beats branch, then sticky until reset
    step(1, 0, 1, 12'h100, 1);
    chk("halt_pc", pc, 32'h40);
    chk("halt_flag", halted, 32'h1);
    chk("halt_cnt", redirect_count, 32'h1);
    step(1, 0, 1, 12'h200, 0);
    step(1, 0, 0, 12'h0, 0);
    chk("halt_sticky_pc", pc, 32'h40);
    rst = 0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_halted", halted, 32'h0);
    step(0, 0, 0, 12'h0, 0);

    // misaligned target
    step(1, 0, 0, 12'h0, 0);
    step(1, 0, 1, 12'h042, 0);
    chk("misalign_pc", pc, c_TRAP ? 32'h42 : 32'h40);
    chk("misalign_fault", fault, c_TRAP ? 32'h1 : 32'h0);
    step(1, 0, 0, 12'h0, 0);
    step(1, 0, 1, 12'h080, 0);
    step(1, 0, 0, 12'h0, 0);

    // counter saturation on the 4-bit instance
    step(0, 0, 0, 12'h0, 0);
    step(1, 0, 0, 12'h0, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 1, 12'(i * 16), 0);
    chk("sat_count4", redirect_count_s, 32'hF);
    chk("sat_count16", redirect_count, 32'd17);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] t;
      bit r, s, b, h;
      r = ($urandom_range(99) >= 2);
      s = ($urandom_range(99) < 25);
      b = ($urandom_range(99) < 25);
      h = ($urandom_range(199) < 3);
      t = 12'($urandom);
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      step(r, s, b, t, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the KGP-RISC core, sitting directly upstream of instruction fetch. It owns the 12-bit byte-addressed PC and drives it, with a qualifying valid, into the fetch stage's `pc` input. On each clock it advances the PC sequentially, redirects to branch/jump targets, holds on stall, and parks in a sticky halt state. It also keeps a saturating count of taken redirects for debug.

## Interface
Parameters:
- `PC_WIDTH`, 12: PC width in bits; matches the fetch stage `pc` port.
- `RESET_PC`, 12'd0: PC value loaded on reset.
- `STEP`, 4: sequential increment in bytes.
- `CNT_WIDTH`, 16: width of the redirect counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `stall`  in  1  hold PC and `fetch_valid` this cycle.
- `branch_valid`  in  1  redirect request this cycle.
- `branch_target`  in  PC_WIDTH  redirect destination, byte address.
- `halt`  in  1  enter HALT at the next edge.
- `pc`  out  PC_WIDTH  registered current PC, to fetch `pc`.
- `pc_plus4`  out  PC_WIDTH  combinational `pc + STEP`, modulo 2^PC_WIDTH; used as the link value.
- `fetch_valid`  out  1  registered; `pc` names a real-path instruction.
- `halted`  out  1  registered; high in HALT.
- `fault`  out  1  registered; high in FAULT (macro only, else tied 0).
- `redirect_count`  out  CNT_WIDTH  registered count of accepted redirects.

## Operation
- States: BOOT, RUN, BUBBLE, HALT, FAULT (FAULT exists only with the macro).
- Reset (rst=0, asynchronous): state=BOOT, `pc`=RESET_PC, `fetch_valid`=0, `halted`=0, `fault`=0, `redirect_count`=0.
- BOOT: at the first edge with rst=1, go to RUN and set `fetch_valid`=1. `pc` stays RESET_PC. Inputs are ignored in BOOT.
- RUN and BUBBLE: per-edge priority is halt > branch_valid > stall > advance.
  - halt: go to HALT, `halted`=1, `fetch_valid`=0, `pc` held.
  - branch_valid: `pc`=`branch_target`, state=BUBBLE, `fetch_valid`=0, `redirect_count`+1. The branch is accepted even if `stall`=1.
  - stall (no branch): `pc`, `fetch_valid` and state held.
  - advance in RUN: `pc`=`pc`+STEP, wrapping modulo 2^PC_WIDTH (0xFFC -> 0x000).
  - advance in BUBBLE: `pc` held, state=RUN, `fetch_valid`=1. This gives fetch one cycle to settle on the target.
- HALT: absorbing. All inputs are ignored and only reset exits it.
- FAULT: absorbing. `fault`=1, `fetch_valid`=0, `pc` held at the offending target. Only reset exits it.
- `redirect_count` saturates at all-ones and does not wrap.

## Timing
- Redirect latency: `branch_valid` sampled at edge N puts the target on `pc` after edge N with `fetch_valid`=0. `fetch_valid` returns to 1 after edge N+1, unless stall/branch/halt intervenes in BUBBLE.
- A branch arriving in BUBBLE re-redirects: new target, still BUBBLE, counter increments.
- Sequential rate: one PC per cycle while in RUN with `stall`=0.
- `pc_plus4` is purely combinational from the `pc` register (zero latency).
- Reset mid-operation overrides everything immediately, including HALT, FAULT and a pending branch.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect whose `branch_target[1:0]` != 2'b00 goes to FAULT instead of BUBBLE.
  - `pc` is loaded with the raw target, `fault`=1, and `redirect_count` is still incremented.
  - halt keeps its priority over this.
- `PC_MISALIGN_TRAP_EN` undefined:
  - `pc` is loaded with `{branch_target[PC_WIDTH-1:2], 2'b00}`.
  - `fault` is tied 0 and the FAULT state is absent.

## Test plan
- Reset then 4 free-running cycles: `pc` is 0x000 (BOOT, valid=0), then 0x000, 0x004, 0x008, 0x00C with valid=1.
- Wrap: redirect to 0xFF8, wait out the bubble, then 2 cycles: `pc` goes 0xFF8 -> 0xFFC -> 0x000. `pc_plus4` at 0xFFC reads 0x000.
- Branch with stall=1 to 0x040: next cycle `pc`=0x040 with valid=0, then valid=1. `redirect_count`=1. A stall held during the bubble keeps valid=0.
- halt and branch_valid in the same cycle: HALT wins, `pc` held, `halted`=1, count unchanged. Later inputs are ignored until rst=0, which returns `pc`=RESET_PC.
- Misaligned target 0x042:
  - With `PC_MISALIGN_TRAP_EN`: `fault`=1, `pc`=0x042, valid=0, sticky.
  - Without: `pc`=0x040, normal bubble.
- Counter saturation (CNT_WIDTH=4 override): 17 redirects leave `redirect_count`=4'hF.
